// File: rtl/vga_out_pipelined.sv
// rtl/vga_out_pipelined.sv - parameterised VGA output stage with latency-matched renderer requests
// Syncs and active flag are delayed PIPE_LAT+1 stages so they meet the renderer colour at the pin register.
module vga_out_pipelined #(
  parameter int                 H_TOTAL        = 1680,
  parameter int                 V_TOTAL        = 828,
  parameter int                 H_SYNC_END     = 135,
  parameter int                 V_SYNC_END     = 2,
  parameter int                 H_ACTIVE_START = 336,
  parameter int                 H_ACTIVE_END   = 1615,
  parameter int                 V_ACTIVE_START = 27,
  parameter int                 V_ACTIVE_END   = 826,
  parameter logic               HS_POL         = 1'b0,
  parameter logic               VS_POL         = 1'b0,
  parameter int                 COLOR_W        = 4,
  parameter int                 PIPE_LAT       = 2,
  parameter int                 X_W            = 11,
  parameter int                 Y_W            = 10,
  parameter logic [COLOR_W-1:0] BG_R           = '0,
  parameter logic [COLOR_W-1:0] BG_G           = '0,
  parameter logic [COLOR_W-1:0] BG_B           = '0
) (
  input  logic               clk84mhz,
  input  logic               rst,
  input  logic [COLOR_W-1:0] r_in,
  input  logic [COLOR_W-1:0] g_in,
  input  logic [COLOR_W-1:0] b_in,
  output logic [X_W-1:0]     req_x,
  output logic [Y_W-1:0]     req_y,
  output logic               req_valid,
  output logic               line_start,
  output logic               frame_start,
  output logic [15:0]        frame_count,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  output logic               VGA_HS,
  output logic               VGA_VS
);

  if (!(H_SYNC_END < H_ACTIVE_START && H_ACTIVE_START <= H_ACTIVE_END && H_ACTIVE_END < H_TOTAL))
  begin : g_bad_h_timing
    $error("vga_out_pipelined: horizontal timing parameters out of order");
  end
  if (!(V_SYNC_END < V_ACTIVE_START && V_ACTIVE_START <= V_ACTIVE_END && V_ACTIVE_END < V_TOTAL))
  begin : g_bad_v_timing
    $error("vga_out_pipelined: vertical timing parameters out of order");
  end
  if (PIPE_LAT < 0 || PIPE_LAT > 15 || (2 ** X_W) < H_TOTAL || (2 ** Y_W) < V_TOTAL)
  begin : g_bad_widths
    $error("vga_out_pipelined: PIPE_LAT or counter widths out of range");
  end

  localparam logic [X_W-1:0] H_LAST = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] H_SE   = X_W'(H_SYNC_END);
  localparam logic [X_W-1:0] H_AS   = X_W'(H_ACTIVE_START);
  localparam logic [X_W-1:0] H_AE   = X_W'(H_ACTIVE_END);
  localparam logic [Y_W-1:0] V_LAST = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_SE   = Y_W'(V_SYNC_END);
  localparam logic [Y_W-1:0] V_AS   = Y_W'(V_ACTIVE_START);
  localparam logic [Y_W-1:0] V_AE   = Y_W'(V_ACTIVE_END);

  logic [X_W-1:0] hcount;
  logic [Y_W-1:0] vcount;
  logic           hs0, vs0, act0, line0, frame0;

  logic [PIPE_LAT:0]   hs_pipe, vs_pipe, act_pipe;
  logic [PIPE_LAT+1:0] hs_chain, vs_chain, act_chain;

  always_comb begin
    hs0    = (hcount <= H_SE);
    vs0    = (vcount <= V_SE);
    act0   = (hcount >= H_AS) && (hcount <= H_AE) && (vcount >= V_AS) && (vcount <= V_AE);
    line0  = act0 && (hcount == H_AS);
    frame0 = line0 && (vcount == V_AS);
  end

  // Bit 0 of each chain is the undelayed stage-0 flag, so PIPE_LAT=0 still yields one register stage.
  assign hs_chain  = {hs_pipe, hs0};
  assign vs_chain  = {vs_pipe, vs0};
  assign act_chain = {act_pipe, act0};

  always_ff @(posedge clk84mhz) begin
    if (rst) begin
      hcount      <= '0;
      vcount      <= '0;
      req_x       <= '0;
      req_y       <= '0;
      req_valid   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
      hs_pipe     <= '0;
      vs_pipe     <= '0;
      act_pipe    <= '0;
      VGA_HS      <= ~HS_POL;
      VGA_VS      <= ~VS_POL;
      VGA_R       <= BG_R;
      VGA_G       <= BG_G;
      VGA_B       <= BG_B;
    end else begin
      if (hcount == H_LAST) begin
        hcount <= '0;
        vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
      end else begin
        hcount <= hcount + 1'b1;
      end

      req_valid   <= act0;
      line_start  <= line0;
      frame_start <= frame0;
      if (act0) begin
        req_x <= hcount - H_AS;
        req_y <= vcount - V_AS;
      end
      if (frame_start) frame_count <= frame_count + 16'd1;

      hs_pipe  <= hs_chain[PIPE_LAT:0];
      vs_pipe  <= vs_chain[PIPE_LAT:0];
      act_pipe <= act_chain[PIPE_LAT:0];

      VGA_HS <= hs_pipe[PIPE_LAT] ? HS_POL : ~HS_POL;
      VGA_VS <= vs_pipe[PIPE_LAT] ? VS_POL : ~VS_POL;
      VGA_R  <= act_pipe[PIPE_LAT] ? r_in : BG_R;
      VGA_G  <= act_pipe[PIPE_LAT] ? g_in : BG_G;
      VGA_B  <= act_pipe[PIPE_LAT] ? b_in : BG_B;
    end
  end

endmodule

// File: tb/tb_vga_out_pipelined.sv
// tb/tb_vga_out_pipelined.sv - scoreboard bench for vga_out_pipelined on a reduced raster
// Two instances: PIPE_LAT=2/4-bit colour and PIPE_LAT=0/8-bit colour, both with the same small timing.
module tb_vga_out_pipelined;
  localparam int HT = 24, HSE = 2, HAS = 6, HAE = 20;
  localparam int VT = 12, VSE = 1, VAS = 3, VAE = 10;
  localparam int LINES = VAE - VAS + 1;

  logic clk84mhz = 1'b0;
  always #6 clk84mhz = ~clk84mhz;
  logic rst = 1'b1;

  logic [3:0]  r_in, g_in, b_in, vga_r, vga_g, vga_b;
  logic [10:0] req_x, req0_x;
  logic [9:0]  req_y, req0_y;
  logic        req_valid, line_start, frame_start, vga_hs, vga_vs;
  logic [15:0] frame_count, frame0_count;
  logic [7:0]  r0_in, g0_in, b0_in, vga0_r, vga0_g, vga0_b;
  logic        req0_valid, line0_start, frame0_start, vga0_hs, vga0_vs;

  vga_out_pipelined #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC_END(HSE), .V_SYNC_END(VSE),
    .H_ACTIVE_START(HAS), .H_ACTIVE_END(HAE), .V_ACTIVE_START(VAS), .V_ACTIVE_END(VAE),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(4), .PIPE_LAT(2), .X_W(11), .Y_W(10),
    .BG_R(4'h0), .BG_G(4'h0), .BG_B(4'h0)
  ) u_dut (
    .clk84mhz(clk84mhz), .rst(rst), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .req_x(req_x), .req_y(req_y), .req_valid(req_valid), .line_start(line_start),
    .frame_start(frame_start), .frame_count(frame_count),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b), .VGA_HS(vga_hs), .VGA_VS(vga_vs)
  );

  vga_out_pipelined #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC_END(HSE), .V_SYNC_END(VSE),
    .H_ACTIVE_START(HAS), .H_ACTIVE_END(HAE), .V_ACTIVE_START(VAS), .V_ACTIVE_END(VAE),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(8), .PIPE_LAT(0), .X_W(11), .Y_W(10),
    .BG_R(8'h00), .BG_G(8'h00), .BG_B(8'h00)
  ) u_dut0 (
    .clk84mhz(clk84mhz), .rst(rst), .r_in(r0_in), .g_in(g0_in), .b_in(b0_in),
    .req_x(req0_x), .req_y(req0_y), .req_valid(req0_valid), .line_start(line0_start),
    .frame_start(frame0_start), .frame_count(frame0_count),
    .VGA_R(vga0_r), .VGA_G(vga0_g), .VGA_B(vga0_b), .VGA_HS(vga0_hs), .VGA_VS(vga0_vs)
  );

  // Renderer models: two-cycle registered for u_dut, combinational for u_dut0.
  logic [3:0] rx1, ry1, rx2, ry2;
  always @(posedge clk84mhz) begin
    rx1 <= req_x[3:0];
    ry1 <= req_y[3:0];
    rx2 <= rx1;
    ry2 <= ry1;
  end
  assign r_in  = rx2;
  assign g_in  = ry2;
  assign b_in  = 4'hA;
  assign r0_in = {req0_x[3:0], req0_y[3:0]};
  assign g0_in = ~{req0_x[3:0], req0_y[3:0]};
  assign b0_in = 8'h5A;

  int checks = 0, errors = 0;
  int th, tv, exp_rx, exp_ry, fc_model, n_frame, n_line;
  bit mon_en = 1'b0;
  logic [13:0] q[$];
  logic [25:0] q0[$];
  localparam logic [13:0] IDLE  = {2'b11, 12'h0};
  localparam logic [25:0] IDLE0 = {2'b11, 24'h0};

  function automatic bit is_act(int h, int v);
    return h >= HAS && h <= HAE && v >= VAS && v <= VAE;
  endfunction

  function automatic logic [13:0] exp_pins(int h, int v);
    logic [3:0] x, y;
    x = 4'(h - HAS);
    y = 4'(v - VAS);
    return {h > HSE, v > VSE, is_act(h, v) ? {x, y, 4'hA} : 12'h0};
  endfunction

  function automatic logic [25:0] exp_pins0(int h, int v);
    logic [3:0] x, y;
    x = 4'(h - HAS);
    y = 4'(v - VAS);
    return {h > HSE, v > VSE, is_act(h, v) ? {x, y, ~{x, y}, 8'h5A} : 24'h0};
  endfunction

  always @(posedge clk84mhz) begin
    #1;
    if (mon_en) begin
      bit act, ln, fr;
      logic [13:0] e;
      logic [25:0] e0;
      act = is_act(th, tv);
      ln  = act && th == HAS;
      fr  = ln && tv == VAS;
      if (act) begin
        exp_rx = th - HAS;
        exp_ry = tv - VAS;
      end
      checks++;
      if ({req_valid, line_start, frame_start, req_x, req_y} !== {act, ln, fr, 11'(exp_rx), 10'(exp_ry)}) begin
        errors++;
        $display("FAIL req: got v=%b l=%b f=%b x=%0d y=%0d, expected v=%b l=%b f=%b x=%0d y=%0d",
                 req_valid, line_start, frame_start, req_x, req_y, act, ln, fr, exp_rx, exp_ry);
      end
      checks++;
      if ({req0_valid, line0_start, frame0_start, req0_x, req0_y} !== {act, ln, fr, 11'(exp_rx), 10'(exp_ry)}) begin
        errors++;
        $display("FAIL req_lat0: got v=%b x=%0d y=%0d, expected v=%b x=%0d y=%0d",
                 req0_valid, req0_x, req0_y, act, exp_rx, exp_ry);
      end
      checks++;
      if (frame_count !== 16'(fc_model)) begin
        errors++;
        $display("FAIL frame_count: got %0d expected %0d", frame_count, fc_model);
      end
      if (fr) fc_model++;
      if (frame_start) n_frame++;
      if (line_start) n_line++;
      if (th == HT - 1) begin
        th = 0;
        tv = (tv == VT - 1) ? 0 : tv + 1;
      end else begin
        th++;
      end
      q.push_back(exp_pins(th, tv));
      q0.push_back(exp_pins0(th, tv));
      e  = q.pop_front();
      e0 = q0.pop_front();
      checks++;
      if ({vga_hs, vga_vs, vga_r, vga_g, vga_b} !== e) begin
        errors++;
        $display("FAIL pins: got %h expected %h (h=%0d v=%0d)", {vga_hs, vga_vs, vga_r, vga_g, vga_b}, e, th, tv);
      end
      checks++;
      if ({vga0_hs, vga0_vs, vga0_r, vga0_g, vga0_b} !== e0) begin
        errors++;
        $display("FAIL pins_lat0: got %h expected %h (h=%0d v=%0d)",
                 {vga0_hs, vga0_vs, vga0_r, vga0_g, vga0_b}, e0, th, tv);
      end
    end
  end

  task automatic do_reset(input int n);
    @(negedge clk84mhz);
    mon_en = 1'b0;
    rst = 1'b1;
    repeat (n) @(negedge clk84mhz);
    rst = 1'b0;
  endtask

  // Called at the negedge of the first post-reset cycle (counters at 0,0).
  task automatic init_model();
    th = 0; tv = 0; exp_rx = 0; exp_ry = 0; fc_model = 0; n_frame = 0; n_line = 0;
    q  = {IDLE, IDLE, IDLE, exp_pins(0, 0)};
    q0 = {IDLE0, exp_pins0(0, 0)};
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(3);
    checks++;
    if ({req_valid, line_start, frame_start, req_x, req_y, frame_count, vga_hs, vga_vs, vga_r, vga_g, vga_b}
        !== {3'b000, 21'h0, 16'h0, 2'b11, 12'h0}) begin
      errors++;
      $display("FAIL reset_state: got req=%b%b%b x=%0d y=%0d fc=%0d hs=%b vs=%b rgb=%h, expected zeros with hs=vs=1",
               req_valid, line_start, frame_start, req_x, req_y, frame_count, vga_hs, vga_vs, {vga_r, vga_g, vga_b});
    end
    checks++;
    if ({req0_valid, frame0_count, vga0_hs, vga0_vs, vga0_r, vga0_g, vga0_b} !== {1'b0, 16'h0, 2'b11, 24'h0}) begin
      errors++;
      $display("FAIL reset_state_lat0: got hs=%b vs=%b rgb=%h, expected hs=1 vs=1 rgb=0",
               vga0_hs, vga0_vs, {vga0_r, vga0_g, vga0_b});
    end
    init_model();
    for (int c = 0; c <= 5; c++) begin
      checks++;
      if (vga_hs !== (c < 4 ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL hs_lead_in: cycle %0d got %b expected %b", c, vga_hs, c < 4);
      end
      @(negedge clk84mhz);
    end
  endtask

  task automatic test_pixel();
    int c;
    do_reset(1);
    init_model();
    c = (VAS + 3) * HT + HAS + 5;
    repeat (c + 2) @(negedge clk84mhz);
    checks++;
    if ({vga0_r, vga0_g, vga0_b} !== 24'h53_AC_5A) begin
      errors++;
      $display("FAIL pixel_5_3_lat0: got %h expected 53ac5a", {vga0_r, vga0_g, vga0_b});
    end
    repeat (2) @(negedge clk84mhz);
    checks++;
    if ({vga_r, vga_g, vga_b} !== 12'h53A) begin
      errors++;
      $display("FAIL pixel_5_3: got %h expected 53a", {vga_r, vga_g, vga_b});
    end
  endtask

  task automatic test_frames();
    do_reset(1);
    init_model();
    repeat (3 * HT * VT) @(negedge clk84mhz);
    checks++;
    if (n_frame !== 3) begin
      errors++;
      $display("FAIL frame_pulses: got %0d expected 3", n_frame);
    end
    checks++;
    if (n_line !== 3 * LINES) begin
      errors++;
      $display("FAIL line_pulses: got %0d expected %0d", n_line, 3 * LINES);
    end
    checks++;
    if (frame_count !== 16'd3) begin
      errors++;
      $display("FAIL frame_count_3: got %0d expected 3", frame_count);
    end
  endtask

  task automatic test_midframe_reset();
    do_reset(1);
    init_model();
    repeat (HT * VT + 5 * HT + 15) @(negedge clk84mhz);
    do_reset(1);
    checks++;
    if ({req_valid, line_start, frame_start, req_x, req_y, frame_count, vga_hs, vga_vs, vga_r, vga_g, vga_b}
        !== {3'b000, 21'h0, 16'h0, 2'b11, 12'h0}) begin
      errors++;
      $display("FAIL midframe_reset_state: got fc=%0d x=%0d y=%0d hs=%b vs=%b rgb=%h, expected zeros with hs=vs=1",
               frame_count, req_x, req_y, vga_hs, vga_vs, {vga_r, vga_g, vga_b});
    end
    init_model();
    repeat (2 * HT * VT) @(negedge clk84mhz);
    checks++;
    if (frame_count !== 16'd2 || n_frame !== 2) begin
      errors++;
      $display("FAIL restart_frames: got fc=%0d pulses=%0d expected 2 and 2", frame_count, n_frame);
    end
  endtask

  initial begin
    test_reset();
    test_pixel();
    test_frames();
    test_midframe_reset();
    mon_en = 1'b0;
    @(negedge clk84mhz);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_out_pipelined.md
Name: vga_out_pipelined

Overview:
- Next-generation VGA output stage with VGA timing and polarity set by parameters.
- Issues registered pixel-coordinate requests to a renderer whose latency is PIPE_LAT cycles.
- Delays sync and active flags to match that latency, so colour, HS and VS reach the pins aligned.
- Sits between the frame renderer (sprite/tile compositor) and the board VGA pins; also gives the game logic frame/line strobes and a frame counter.

Parameters:
H_TOTAL, 1680, pixel clocks per line
V_TOTAL, 828, lines per frame
H_SYNC_END, 135, last hcount of HS pulse (pulse = hcount 0..H_SYNC_END)
V_SYNC_END, 2, last vcount of VS pulse (pulse = vcount 0..V_SYNC_END)
H_ACTIVE_START, 336, first visible hcount
H_ACTIVE_END, 1615, last visible hcount
V_ACTIVE_START, 27, first visible vcount
V_ACTIVE_END, 826, last visible vcount
HS_POL, 1'b0, HS level during pulse
VS_POL, 1'b0, VS level during pulse
COLOR_W, 4, bits per colour channel
PIPE_LAT, 2, renderer latency in cycles, req to rgb_in; 0..15 legal, 0 = combinational renderer
X_W, 11, width of hcount and req_x; requires 2**X_W >= H_TOTAL
Y_W, 10, width of vcount and req_y; requires 2**Y_W >= V_TOTAL
BG_R/BG_G/BG_B, 0, colour driven outside the active area

Ports:
clk84mhz  in  1  pixel clock, 83.46 MHz
rst  in  1  synchronous, active-high reset
r_in/g_in/b_in  in  COLOR_W each  renderer colour for the request issued PIPE_LAT cycles earlier
req_x  out  X_W  requested column, 0..H_ACTIVE_END-H_ACTIVE_START
req_y  out  Y_W  requested row, 0..V_ACTIVE_END-V_ACTIVE_START
req_valid  out  1  req_x/req_y name a visible pixel this cycle
line_start  out  1  one-cycle pulse with req_valid && req_x==0
frame_start  out  1  one-cycle pulse with req_valid && req_x==0 && req_y==0
frame_count  out  16  completed frame_start count, wraps 0xFFFF->0
VGA_R/VGA_G/VGA_B  out  COLOR_W each  registered colour to pins
VGA_HS/VGA_VS  out  1  registered syncs to pins

Behaviour:
- Counters: hcount runs 0..H_TOTAL-1; at wrap it returns to 0 and vcount increments, wrapping V_TOTAL-1->0.
- Stage 0 (cycle n): decode from the counters.
  - hs0 = (hcount<=H_SYNC_END), vs0 = (vcount<=V_SYNC_END).
  - act0 = hcount in [H_ACTIVE_START,H_ACTIVE_END] and vcount in [V_ACTIVE_START,V_ACTIVE_END].
- Stage 1 (cycle n+1), registered outputs:
  - req_valid=act0.
  - When act0: req_x=hcount-H_ACTIVE_START, req_y=vcount-V_ACTIVE_START. Otherwise both hold their last value.
  - line_start and frame_start are registered from the stage-0 equivalents.
- Renderer: returns colour for the stage-1 request during cycle n+1+PIPE_LAT. The block never stalls; there is no backpressure.
- Delay line: hs0, vs0 and act0 pass through a shift register of PIPE_LAT+1 stages to reach the output register.
- Output register, captured at the end of cycle n+1+PIPE_LAT, visible on pins in cycle n+2+PIPE_LAT:
  - VGA_HS = hs_d ? HS_POL : ~HS_POL (same form for VS).
  - VGA_RGB = act_d ? rgb_in : BG.
- Total counter-to-pin latency is PIPE_LAT+2 for colour, HS and VS alike.
- frame_count increments in the cycle after frame_start is high.
- Reset (any cycle, including mid-line or mid-frame):
  - hcount, vcount, req_x, req_y = 0; req_valid, line_start, frame_start = 0; frame_count = 0.
  - All delay stages cleared to inactive (sync off, act 0).
  - VGA_HS=~HS_POL, VGA_VS=~VS_POL, VGA_RGB=BG.
  - First cycle after release is hcount=0, vcount=0. Pins show the first HS pulse PIPE_LAT+2 cycles later and stay idle until then.
- Arithmetic:
  - Subtractions are unsigned at X_W/Y_W and are only evaluated when act0, so they never underflow.
  - Parameter ordering (SYNC_END < ACTIVE_START <= ACTIVE_END < TOTAL) is checked by an elaboration assertion.

Test Plan:
- Reset release, defaults → VGA_HS stays 1 for 4 cycles, then 0 for 136 cycles, then 1 for 1544 cycles; the 1680-cycle pattern repeats.
- Run a full frame → VS is low for 3×1680=5040 cycles per 828×1680=1,391,040-cycle frame; HS and VS edges are offset from counter edges by exactly 4 cycles.
- Renderer model returning {req_x[3:0], req_y[3:0], 4'hA} delayed PIPE_LAT=2 → every active pixel on pins equals the model for its (x,y), e.g. pixel (5,3) gives R=5,G=3,B=A. Outside active the pins show BG=0; there are exactly 1280 active pins per active line.
- Run 3 frames → frame_start pulses 3 times, each coinciding with req_x=0, req_y=0, req_valid=1. line_start pulses 800 times per frame. frame_count=3.
- rst for 1 cycle at hcount≈700 of frame 1 → next cycle all outputs are at reset values and frame_count=0; the timing restarts with the same 4-cycle idle lead-in.
- Re-elaborate with PIPE_LAT=0 and COLOR_W=8 → colour, HS and VS latency is 2 cycles; 8-bit pass-through of r_in is bit-exact.
